adpll_lock_ctrl_5bit: RTL and testbench
=======================================

Name: adpll_lock_ctrl_5bit

Overview:
Sequencing controller for the 5-bit ADPLL loop. It coarse-tunes the NCO offset with a 5-step binary search while the loop is held open. It then closes the loop with high "acquire" PI gains and gear-shifts to low "track" gains. Once the loop is locked it monitors phase error, and falls back to acquisition if lock is lost. Its outputs drive the loop's alpha_var, beta_var and nco_offset inputs, plus a hold into the PI filter reset. It watches the TDC ones-counter outputs (up/down binary error).

Parameters:
ALPHA_ACQ, 5'd8, proportional gain in ACQ
BETA_ACQ, 5'd4, integral gain in ACQ
ALPHA_TRK, 5'd2, proportional gain in TRACK/LOCKED
BETA_TRK, 5'd1, integral gain in TRACK/LOCKED
OFFSET_INIT, 5'd16, nco_offset reset value
SETTLE, 4, ref ticks discarded after each coarse trial change
WIN_LOG2, 3, log2 of coarse measurement window in ref ticks (window = 8)
LOCK_THRESH, 1, |error| <= this counts as "small"
LOCK_CNT, 16, consecutive small ticks to advance ACQ->TRACK and TRACK->LOCKED
UNLOCK_THRESH, 4, |error| > this counts as "large"
UNLOCK_CNT, 4, consecutive large ticks in LOCKED to declare unlock

Ports:
clk  input  1  system clock; all logic is on its rising edge
reset  input  1  synchronous, active-high reset
clk_ref  input  1  reference clock, sampled as data (asynchronous to clk)
start  input  1  level; in IDLE, begins the sequence
stop  input  1  level; forces IDLE from any state, and has priority over start
bin_up_error  input  5  unsigned up-error count (0..31)
bin_dwn_error  input  5  unsigned down-error count (0..31)
alpha_var  output  5  proportional gain to the PI filter
beta_var  output  5  integral gain to the PI filter
nco_offset  output  5  NCO offset word
loop_hold  output  1  high while the loop is open (IDLE, COARSE); ORed into the PI filter reset
locked  output  1  high only in LOCKED
unlock_pulse  output  1  one clk cycle pulse on LOCKED->ACQ
state  output  3  IDLE=0, COARSE=1, ACQ=2, TRACK=3, LOCKED=4

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, alpha_var=ALPHA_ACQ, beta_var=BETA_ACQ, nco_offset=OFFSET_INIT, loop_hold=1, locked=0, unlock_pulse=0. All counters and the accumulator clear to 0.
- ref_tick: clk_ref passes through a 2-flop synchronizer, then a rising-edge detect. ref_tick is a one-cycle pulse, 3 clk cycles after a clk_ref rise.
- All error sampling happens only on ref_tick cycles.
- err = bin_up_error - bin_dwn_error, 6-bit signed, range -31..+31. mag = |err|, 5 bits.
- IDLE: loop_hold=1 and the gains are the ACQ values. nco_offset holds its value. On start & !stop:
  - go to COARSE;
  - nco_offset <= 5'b10000; bit index <= 4;
  - tick counter and accumulator cleared.
- COARSE, per bit:
  - ignore SETTLE ticks, then add err into the signed accumulator on 2^WIN_LOG2 ticks.
  - The accumulator is 6+WIN_LOG2 bits wide and cannot overflow.
  - The decision uses the accumulator including the final window sample, and is registered on that final tick's edge.
  - If acc < 0 (NCO fast), clear the current bit; otherwise keep it.
  - If index > 0, set bit index-1, decrement the index, and clear the counters. If index == 0, go to ACQ.
  - The new nco_offset is visible the cycle after the deciding tick.
  - Total duration is 5*(SETTLE+2^WIN_LOG2) ticks.
- ACQ: loop_hold=0, gains are the ACQ values.
  - lock_cnt increments on a tick with mag <= LOCK_THRESH and clears on any other tick.
  - When lock_cnt reaches LOCK_CNT, go to TRACK and clear lock_cnt.
- TRACK: gains are the TRK values; same counting as ACQ. When lock_cnt reaches LOCK_CNT, go to LOCKED.
- LOCKED: locked=1, gains are the TRK values.
  - unlock_cnt increments on a tick with mag > UNLOCK_THRESH and clears on any other tick.
  - When unlock_cnt reaches UNLOCK_CNT: go to ACQ, pulse unlock_pulse, locked=0, and clear both counters.
  - nco_offset is unchanged.
- Counters saturate and never wrap.
- Gains change on the same edge as the state register.
- stop in any state: IDLE on the next edge, with counters cleared and nco_offset retained.
- stop and start both high: stays in IDLE.
- start outside IDLE is ignored.
- reset wins over everything, including mid-COARSE and in LOCKED.
- Non-tick cycles change nothing except the synchronizer.

Test Plan:
- Reset: hold reset 3 cycles, toggle clk_ref -> state=0, nco_offset=16, alpha_var=8, beta_var=4, loop_hold=1, locked=0.
- Coarse search: bench model gives up=3, dwn=0 if offset<19; up=0, dwn=3 if offset>19; 0/0 if offset=19. Pulse start. Required trial sequence is 16,24,20,18,19. Required result: final nco_offset=19, entry to ACQ after 60 ticks, loop_hold falling on the same edge.
- Gear shift: from ACQ, drive up=dwn=0. Required: after 16 ticks state=3 and alpha/beta=2/1; after 16 more, state=4 and locked=1.
- Count restart: in ACQ give 15 small ticks, then 1 tick with up=2, dwn=0, then small ticks. Required: TRACK is entered only after 16 further small ticks (32 ticks total).
- Unlock: in LOCKED give 3 ticks with mag 6, then 1 with mag 0. Required: remains LOCKED. Then give 4 ticks with mag 6. Required: state=2, locked=0, unlock_pulse high exactly 1 cycle, gains 8/4, nco_offset unchanged.
- Abort: assert stop mid-COARSE (bit 2) -> IDLE next edge, nco_offset retained, loop_hold=1. Then assert reset while LOCKED -> all reset values next edge.

Source files
------------

// File: rtl/adpll_lock_ctrl_5bit.sv
// ADPLL lock sequencer: 5-step coarse binary search on nco_offset with the loop open,
// then closed-loop ACQ -> TRACK -> LOCKED gear shifting with lock-loss fallback.
module adpll_lock_ctrl_5bit #(
  parameter logic [4:0] ALPHA_ACQ     = 5'd8,
  parameter logic [4:0] BETA_ACQ      = 5'd4,
  parameter logic [4:0] ALPHA_TRK     = 5'd2,
  parameter logic [4:0] BETA_TRK      = 5'd1,
  parameter logic [4:0] OFFSET_INIT   = 5'd16,
  parameter int         SETTLE        = 4,
  parameter int         WIN_LOG2      = 3,
  parameter int         LOCK_THRESH   = 1,
  parameter int         LOCK_CNT      = 16,
  parameter int         UNLOCK_THRESH = 4,
  parameter int         UNLOCK_CNT    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_ref,
  input  logic       start,
  input  logic       stop,
  input  logic [4:0] bin_up_error,
  input  logic [4:0] bin_dwn_error,
  output logic [4:0] alpha_var,
  output logic [4:0] beta_var,
  output logic [4:0] nco_offset,
  output logic       loop_hold,
  output logic       locked,
  output logic       unlock_pulse,
  output logic [2:0] state
);

  localparam int ACC_W = 6 + WIN_LOG2;
  localparam int TC_W  = $clog2(SETTLE + (1 << WIN_LOG2));
  localparam int LC_W  = $clog2(LOCK_CNT + 1);
  localparam int UC_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic [TC_W-1:0] SETTLE_V    = TC_W'(SETTLE);
  localparam logic [TC_W-1:0] LAST_V      = TC_W'(SETTLE + (1 << WIN_LOG2) - 1);
  localparam logic [LC_W-1:0] LOCK_CNT_V  = LC_W'(LOCK_CNT);
  localparam logic [UC_W-1:0] UNLK_CNT_V  = UC_W'(UNLOCK_CNT);
  localparam logic [4:0]      LOCK_TH_V   = 5'(LOCK_THRESH);
  localparam logic [4:0]      UNLK_TH_V   = 5'(UNLOCK_THRESH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COARSE = 3'd1,
    S_ACQ    = 3'd2,
    S_TRACK  = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t cur_state, nxt_state;

  logic ref_s1, ref_s2, ref_s3, ref_tick;
  logic [2:0]              bit_idx, bit_idx_d;
  logic [TC_W-1:0]         tick_cnt, tick_cnt_d;
  logic signed [ACC_W-1:0] acc, acc_d, acc_sum;
  logic [LC_W-1:0]         lock_cnt, lock_cnt_d, lock_inc;
  logic [UC_W-1:0]         unlock_cnt, unlock_cnt_d, unlock_inc;
  logic [4:0]              nco_d, bit_mask, trial;
  logic signed [5:0]       err;
  logic [5:0]              neg_err;
  logic [4:0]              mag;
  logic [4:0]              alpha_d, beta_d;
  logic                    loop_hold_d, locked_d, unlock_pulse_d;

  assign state    = cur_state;
  assign err      = $signed({1'b0, bin_up_error}) - $signed({1'b0, bin_dwn_error});
  assign neg_err  = -err;
  assign mag      = err[5] ? neg_err[4:0] : err[4:0];
  assign acc_sum  = acc + {{(ACC_W-6){err[5]}}, err};
  assign lock_inc   = (lock_cnt == LOCK_CNT_V) ? lock_cnt : lock_cnt + 1'b1;
  assign unlock_inc = (unlock_cnt == UNLK_CNT_V) ? unlock_cnt : unlock_cnt + 1'b1;
  // Clear the bit under trial if the NCO ran fast, then raise the next lower trial bit.
  assign bit_mask = 5'b00001 << bit_idx;
  assign trial    = (acc_sum < 0 ? (nco_offset & ~bit_mask) : nco_offset) | (bit_mask >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_s1       <= 1'b0;
      ref_s2       <= 1'b0;
      ref_s3       <= 1'b0;
      ref_tick     <= 1'b0;
      cur_state    <= S_IDLE;
      bit_idx      <= 3'd0;
      tick_cnt     <= '0;
      acc          <= '0;
      lock_cnt     <= '0;
      unlock_cnt   <= '0;
      nco_offset   <= OFFSET_INIT;
      alpha_var    <= ALPHA_ACQ;
      beta_var     <= BETA_ACQ;
      loop_hold    <= 1'b1;
      locked       <= 1'b0;
      unlock_pulse <= 1'b0;
    end else begin
      ref_s1       <= clk_ref;
      ref_s2       <= ref_s1;
      ref_s3       <= ref_s2;
      ref_tick     <= ref_s2 & ~ref_s3;
      cur_state    <= nxt_state;
      bit_idx      <= bit_idx_d;
      tick_cnt     <= tick_cnt_d;
      acc          <= acc_d;
      lock_cnt     <= lock_cnt_d;
      unlock_cnt   <= unlock_cnt_d;
      nco_offset   <= nco_d;
      alpha_var    <= alpha_d;
      beta_var     <= beta_d;
      loop_hold    <= loop_hold_d;
      locked       <= locked_d;
      unlock_pulse <= unlock_pulse_d;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    bit_idx_d    = bit_idx;
    tick_cnt_d   = tick_cnt;
    acc_d        = acc;
    lock_cnt_d   = lock_cnt;
    unlock_cnt_d = unlock_cnt;
    nco_d        = nco_offset;
    if (stop) begin
      nxt_state    = S_IDLE;
      tick_cnt_d   = '0;
      acc_d        = '0;
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
    end else begin
      case (cur_state)
        S_IDLE: if (start) begin
          nxt_state    = S_COARSE;
          nco_d        = 5'b10000;
          bit_idx_d    = 3'd4;
          tick_cnt_d   = '0;
          acc_d        = '0;
          lock_cnt_d   = '0;
          unlock_cnt_d = '0;
        end
        S_COARSE: if (ref_tick) begin
          if (tick_cnt < SETTLE_V) begin
            tick_cnt_d = tick_cnt + 1'b1;
          end else if (tick_cnt == LAST_V) begin
            nco_d      = trial;
            tick_cnt_d = '0;
            acc_d      = '0;
            if (bit_idx != 3'd0) bit_idx_d = bit_idx - 3'd1;
            else                 nxt_state = S_ACQ;
          end else begin
            tick_cnt_d = tick_cnt + 1'b1;
            acc_d      = acc_sum;
          end
        end
        S_ACQ, S_TRACK: if (ref_tick) begin
          if (mag <= LOCK_TH_V) begin
            if (lock_inc == LOCK_CNT_V) begin
              nxt_state  = (cur_state == S_ACQ) ? S_TRACK : S_LOCKED;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_inc;
            end
          end else begin
            lock_cnt_d = '0;
          end
        end
        S_LOCKED: if (ref_tick) begin
          if (mag > UNLK_TH_V) begin
            if (unlock_inc == UNLK_CNT_V) begin
              nxt_state    = S_ACQ;
              lock_cnt_d   = '0;
              unlock_cnt_d = '0;
            end else begin
              unlock_cnt_d = unlock_inc;
            end
          end else begin
            unlock_cnt_d = '0;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    alpha_d        = ALPHA_ACQ;
    beta_d         = BETA_ACQ;
    loop_hold_d    = 1'b0;
    locked_d       = 1'b0;
    unlock_pulse_d = 1'b0;
    case (nxt_state)
      S_IDLE, S_COARSE: loop_hold_d = 1'b1;
      S_TRACK: begin
        alpha_d = ALPHA_TRK;
        beta_d  = BETA_TRK;
      end
      S_LOCKED: begin
        alpha_d  = ALPHA_TRK;
        beta_d   = BETA_TRK;
        locked_d = 1'b1;
      end
      default: ;
    endcase
    if (cur_state == S_LOCKED && nxt_state == S_ACQ) unlock_pulse_d = 1'b1;
  end

endmodule

// File: tb/tb_adpll_lock_ctrl_5bit.sv
// Directed bench for adpll_lock_ctrl_5bit: reset, coarse search, gear shift, count restart,
// unlock, start/stop handling and reset while LOCKED.
module tb_adpll_lock_ctrl_5bit;

  logic       clk;
  logic       reset;
  logic       clk_ref;
  logic       start;
  logic       stop;
  logic [4:0] bin_up_error;
  logic [4:0] bin_dwn_error;
  logic [4:0] alpha_var;
  logic [4:0] beta_var;
  logic [4:0] nco_offset;
  logic       loop_hold;
  logic       locked;
  logic       unlock_pulse;
  logic [2:0] state;

  int checks = 0;
  int passes = 0;
  int pulse_seen = 0;
  logic [4:0] exp_q[$];

  adpll_lock_ctrl_5bit dut (
    .clk           (clk),
    .reset         (reset),
    .clk_ref       (clk_ref),
    .start         (start),
    .stop          (stop),
    .bin_up_error  (bin_up_error),
    .bin_dwn_error (bin_dwn_error),
    .alpha_var     (alpha_var),
    .beta_var      (beta_var),
    .nco_offset    (nco_offset),
    .loop_hold     (loop_hold),
    .locked        (locked),
    .unlock_pulse  (unlock_pulse),
    .state         (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (unlock_pulse === 1'b1) pulse_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_tick(input logic [4:0] up, input logic [4:0] dwn);
    @(negedge clk);
    bin_up_error  = up;
    bin_dwn_error = dwn;
    clk_ref = 1'b1;
    repeat (4) @(negedge clk);
    clk_ref = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Plant: NCO is slow below offset 19, fast above it.
  task automatic plant_tick();
    if (nco_offset < 5'd19)      do_tick(5'd3, 5'd0);
    else if (nco_offset > 5'd19) do_tick(5'd0, 5'd3);
    else                         do_tick(5'd0, 5'd0);
  endtask

  task automatic small_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(5'd0, 5'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clk_ref = ~clk_ref;
    end
    reset = 1'b0;
    clk_ref = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_state", 8'(state), 8'd0);
    chk("reset_offset", 8'(nco_offset), 8'd16);
    chk("reset_alpha", 8'(alpha_var), 8'd8);
    chk("reset_beta", 8'(beta_var), 8'd4);
    chk("reset_hold", 8'(loop_hold), 8'd1);
    chk("reset_locked", 8'(locked), 8'd0);
    chk("reset_unlock_pulse", 8'(unlock_pulse), 8'd0);
  endtask

  task automatic test_coarse();
    exp_q = '{5'd16, 5'd24, 5'd20, 5'd18, 5'd19};
    pulse_start();
    chk("coarse_enter_state", 8'(state), 8'd1);
    chk("coarse_enter_hold", 8'(loop_hold), 8'd1);
    for (int i = 0; i < 60; i++) begin
      if (i % 12 == 0) chk($sformatf("coarse_trial_%0d", i / 12), 8'(nco_offset), 8'(exp_q.pop_front()));
      if (i == 59) begin
        chk("coarse_before_last_state", 8'(state), 8'd1);
        chk("coarse_before_last_hold", 8'(loop_hold), 8'd1);
      end
      plant_tick();
    end
    chk("coarse_final_offset", 8'(nco_offset), 8'd19);
    chk("coarse_acq_state", 8'(state), 8'd2);
    chk("coarse_acq_hold", 8'(loop_hold), 8'd0);
    chk("coarse_acq_alpha", 8'(alpha_var), 8'd8);
  endtask

  task automatic test_gear_shift();
    small_ticks(15);
    chk("gear_acq_15", 8'(state), 8'd2);
    small_ticks(1);
    chk("gear_track_state", 8'(state), 8'd3);
    chk("gear_track_alpha", 8'(alpha_var), 8'd2);
    chk("gear_track_beta", 8'(beta_var), 8'd1);
    chk("gear_track_locked", 8'(locked), 8'd0);
    small_ticks(15);
    chk("gear_track_15", 8'(state), 8'd3);
    small_ticks(1);
    chk("gear_locked_state", 8'(state), 8'd4);
    chk("gear_locked_flag", 8'(locked), 8'd1);
    chk("gear_locked_alpha", 8'(alpha_var), 8'd2);
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 3; i++) do_tick(5'd6, 5'd0);
    do_tick(5'd0, 5'd0);
    chk("unlock_interrupted_state", 8'(state), 8'd4);
    pulse_seen = 0;
    for (int i = 0; i < 3; i++) do_tick(5'd0, 5'd6);
    chk("unlock_3_state", 8'(state), 8'd4);
    chk("unlock_3_locked", 8'(locked), 8'd1);
    do_tick(5'd6, 5'd0);
    chk("unlock_state", 8'(state), 8'd2);
    chk("unlock_locked", 8'(locked), 8'd0);
    chk("unlock_pulse_cycles", 8'(pulse_seen), 8'd1);
    chk("unlock_alpha", 8'(alpha_var), 8'd8);
    chk("unlock_beta", 8'(beta_var), 8'd4);
    chk("unlock_offset", 8'(nco_offset), 8'd19);
  endtask

  task automatic test_count_restart();
    small_ticks(15);
    do_tick(5'd2, 5'd0);
    chk("restart_after_big", 8'(state), 8'd2);
    small_ticks(15);
    chk("restart_31_ticks", 8'(state), 8'd2);
    small_ticks(1);
    chk("restart_32_ticks", 8'(state), 8'd3);
  endtask

  task automatic test_start_ignored();
    pulse_start();
    repeat (3) @(negedge clk);
    chk("start_ignored_state", 8'(state), 8'd3);
  endtask

  task automatic test_abort();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_track_state", 8'(state), 8'd0);
    chk("stop_track_offset", 8'(nco_offset), 8'd19);
    chk("stop_track_hold", 8'(loop_hold), 8'd1);
    pulse_start();
    chk("abort_restart_offset", 8'(nco_offset), 8'd16);
    for (int i = 0; i < 24; i++) plant_tick();
    chk("abort_bit2_trial", 8'(nco_offset), 8'd20);
    for (int i = 0; i < 5; i++) plant_tick();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    chk("abort_state", 8'(state), 8'd0);
    chk("abort_offset", 8'(nco_offset), 8'd20);
    chk("abort_hold", 8'(loop_hold), 8'd1);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("stop_start_state", 8'(state), 8'd0);
    stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_offset", 8'(nco_offset), 8'd16);
    for (int i = 0; i < 60; i++) plant_tick();
    chk("rerun_offset", 8'(nco_offset), 8'd19);
    chk("rerun_state", 8'(state), 8'd2);
    small_ticks(32);
    chk("rerun_locked_state", 8'(state), 8'd4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_locked_state", 8'(state), 8'd0);
    chk("rst_locked_offset", 8'(nco_offset), 8'd16);
    chk("rst_locked_alpha", 8'(alpha_var), 8'd8);
    chk("rst_locked_beta", 8'(beta_var), 8'd4);
    chk("rst_locked_hold", 8'(loop_hold), 8'd1);
    chk("rst_locked_flag", 8'(locked), 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    clk_ref = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    bin_up_error = 5'd0;
    bin_dwn_error = 5'd0;
    test_reset();
    test_coarse();
    test_gear_shift();
    test_unlock();
    test_count_restart();
    test_start_ignored();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
